// File: rtl/cpu_pc_stack.sv
// Program counter and circular return-address stack for the 4-bit CPU (JUN/JMS/BBL).
// Define CPU_PC_STACK_ERR_EN to build the sticky stack_ovf/stack_unf flag registers.
module cpu_pc_stack #(
    parameter int          STACK_DEPTH = 3,
    parameter logic [11:0] RESET_PC    = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cycle,
    input  logic [7:0]  inst,
    output logic [3:0]  addr_out,
    output logic        addr_oe,
    output logic [11:0] pc,
    output logic        second_word,
    output logic [2:0]  stack_level,
    output logic        stack_ovf,
    output logic        stack_unf
);

    localparam int         PTR_W    = $clog2(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_DEPTH - 1);
    localparam logic [2:0] LVL_FULL = 3'(STACK_DEPTH);

    typedef enum logic {
        FETCH   = 1'b0,
        OPERAND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [11:0]       pc_next;
    logic [11:0]       pc_inc;
    logic [3:0]        hi;
    logic [3:0]        hi_next;
    logic              is_jms;
    logic              is_jms_next;
    logic              push_en;
    logic              pop_en;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [11:0]       slots [0:STACK_DEPTH-1];

    assign pc_inc      = pc + 12'd1;
    assign ptr_inc     = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec     = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
    assign second_word = (state == OPERAND);

    always_comb begin
        addr_out = 4'h0;
        addr_oe  = 1'b0;
        case (cycle)
            3'd0: begin addr_out = pc[3:0];  addr_oe = 1'b1; end
            3'd1: begin addr_out = pc[7:4];  addr_oe = 1'b1; end
            3'd2: begin addr_out = pc[11:8]; addr_oe = 1'b1; end
            default: ;
        endcase
    end

    // Everything below only advances on the X3 edge; all other edges hold.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        hi_next     = hi;
        is_jms_next = is_jms;
        push_en     = 1'b0;
        pop_en      = 1'b0;
        if (cycle == 3'd7) begin
            case (state)
                FETCH: begin
                    if (inst[7:4] == 4'h4 || inst[7:4] == 4'h5) begin
                        hi_next     = inst[3:0];
                        is_jms_next = inst[4];
                        pc_next     = pc_inc;
                        state_next  = OPERAND;
                    end else if (inst[7:4] == 4'hC) begin
                        pop_en  = 1'b1;
                        pc_next = slots[ptr_dec];
                    end else begin
                        pc_next = pc_inc;
                    end
                end
                OPERAND: begin
                    // The operand byte is pure address data; it is never decoded.
                    pc_next    = {hi, inst};
                    push_en    = is_jms;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            hi     <= 4'h0;
            is_jms <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            hi     <= hi_next;
            is_jms <= is_jms_next;
        end
    end

    // Circular stack: a push when full silently replaces the oldest entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= '0;
            stack_level <= 3'd0;
            for (int i = 0; i < STACK_DEPTH; i++) slots[i] <= 12'h000;
        end else if (push_en) begin
            slots[ptr] <= pc_inc;
            ptr        <= ptr_inc;
            if (stack_level != LVL_FULL) stack_level <= stack_level + 3'd1;
        end else if (pop_en) begin
            ptr <= ptr_dec;
            if (stack_level != 3'd0) stack_level <= stack_level - 3'd1;
        end
    end

`ifdef CPU_PC_STACK_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (push_en && stack_level == LVL_FULL) stack_ovf <= 1'b1;
            if (pop_en && stack_level == 3'd0)      stack_unf <= 1'b1;
        end
    end
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_pc_stack.sv
// Directed table-driven bench for cpu_pc_stack (default depth 3, reset pc 0).
module tb_cpu_pc_stack;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cycle = 3'd0;
    logic [7:0]  inst  = 8'h00;
    logic [3:0]  addr_out;
    logic        addr_oe;
    logic [11:0] pc;
    logic        second_word;
    logic [2:0]  stack_level;
    logic        stack_ovf;
    logic        stack_unf;

`ifdef CPU_PC_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [11:0] cur_pc = 12'h000;
    logic        cur_sw = 1'b0;

    cpu_pc_stack dut (
        .clock       (clock),
        .reset       (reset),
        .cycle       (cycle),
        .inst        (inst),
        .addr_out    (addr_out),
        .addr_oe     (addr_oe),
        .pc          (pc),
        .second_word (second_word),
        .stack_level (stack_level),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  inst;
        logic [11:0] pc;
        logic        sw;
        logic [2:0]  lvl;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full instruction cycle; optionally checks the bus nibbles and held state.
    task automatic run_instr(input logic [7:0] iv, input bit chk);
        logic [3:0] exp_nib;
        for (int c = 0; c < 8; c++) begin
            cycle = 3'(c);
            inst  = iv;
            @(negedge clock);
            if (chk) begin
                case (c)
                    0:       exp_nib = cur_pc[3:0];
                    1:       exp_nib = cur_pc[7:4];
                    2:       exp_nib = cur_pc[11:8];
                    default: exp_nib = 4'h0;
                endcase
                check($sformatf("addr_oe c%0d", c), 32'(addr_oe), 32'(c < 3));
                check($sformatf("addr_out c%0d", c), 32'(addr_out), 32'(exp_nib));
                if (c == 4) begin
                    check("pc held", 32'(pc), 32'(cur_pc));
                    check("second_word", 32'(second_word), 32'(cur_sw));
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        check({tag, " pc"}, 32'(pc), 32'(v.pc));
        check({tag, " second_word"}, 32'(second_word), 32'(v.sw));
        check({tag, " stack_level"}, 32'(stack_level), 32'(v.lvl));
        check({tag, " stack_ovf"}, 32'(stack_ovf), 32'(v.ovf & ERR_EN));
        check({tag, " stack_unf"}, 32'(stack_unf), 32'(v.unf & ERR_EN));
        cur_pc = v.pc;
        cur_sw = v.sw;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle = 3'd0;
        inst  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Post-reset state and the first NOP cycle.
        do_reset();
        check_state("reset", '{8'h00, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0});
        run_instr(8'h00, 1'b1);
        check_state("nop1", '{8'h00, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0});

        // Walk pc up to 0xFFF, then wrap.
        for (int n = 0; n < 4094; n++) run_instr(8'h00, 1'b0);
        check_state("pc_fff", '{8'h00, 12'hFFF, 1'b0, 3'd0, 1'b0, 1'b0});
        run_instr(8'h00, 1'b1);
        check_state("pc_wrap", '{8'h00, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0});

        // inst, pc after X3, second_word, stack_level, ovf, unf
        vecs.push_back('{8'h4A, 12'h001, 1'b1, 3'd0, 1'b0, 1'b0}); // JUN hi=A
        vecs.push_back('{8'h5C, 12'hA5C, 1'b0, 3'd0, 1'b0, 1'b0}); // operand
        vecs.push_back('{8'h40, 12'hA5D, 1'b1, 3'd0, 1'b0, 1'b0}); // JUN 0x010
        vecs.push_back('{8'h10, 12'h010, 1'b0, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h53, 12'h011, 1'b1, 3'd0, 1'b0, 1'b0}); // JMS 0x300
        vecs.push_back('{8'h00, 12'h300, 1'b0, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{8'hC0, 12'h012, 1'b0, 3'd0, 1'b0, 1'b0}); // BBL
        vecs.push_back('{8'h51, 12'h013, 1'b1, 3'd0, 1'b0, 1'b0}); // call 1
        vecs.push_back('{8'h00, 12'h100, 1'b0, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{8'h52, 12'h101, 1'b1, 3'd1, 1'b0, 1'b0}); // call 2
        vecs.push_back('{8'h00, 12'h200, 1'b0, 3'd2, 1'b0, 1'b0});
        vecs.push_back('{8'h53, 12'h201, 1'b1, 3'd2, 1'b0, 1'b0}); // call 3
        vecs.push_back('{8'h00, 12'h300, 1'b0, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{8'h54, 12'h301, 1'b1, 3'd3, 1'b0, 1'b0}); // call 4 overwrites call 1
        vecs.push_back('{8'h00, 12'h400, 1'b0, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{8'hC0, 12'h302, 1'b0, 3'd2, 1'b1, 1'b0}); // back to call 4
        vecs.push_back('{8'hC0, 12'h202, 1'b0, 3'd1, 1'b1, 1'b0}); // call 3
        vecs.push_back('{8'hC0, 12'h102, 1'b0, 3'd0, 1'b1, 1'b0}); // call 2
        vecs.push_back('{8'hC0, 12'h302, 1'b0, 3'd0, 1'b1, 1'b1}); // empty pop, slot 0
        vecs.push_back('{8'h41, 12'h303, 1'b1, 3'd0, 1'b1, 1'b1}); // JUN, operand 0xC5
        vecs.push_back('{8'hC5, 12'h1C5, 1'b0, 3'd0, 1'b1, 1'b1});
        vecs.push_back('{8'hD3, 12'h1C6, 1'b0, 3'd0, 1'b1, 1'b1}); // other opcode
        vecs.push_back('{8'h4F, 12'h1C7, 1'b1, 3'd0, 1'b1, 1'b1}); // JUN, left pending

        foreach (vecs[i]) begin
            run_instr(vecs[i].inst, 1'b1);
            check_state($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset lands on the operand's X3 edge and must win over the jump.
        for (int c = 0; c < 7; c++) begin
            cycle = 3'(c);
            inst  = 8'h77;
            @(posedge clock);
            #1;
        end
        check("pre-reset second_word", 32'(second_word), 32'd1);
        reset = 1'b1;
        cycle = 3'd7;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle = 3'd3;
        check_state("mid_reset", '{8'h00, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0});
        @(negedge clock);
        check("addr_oe idle", 32'(addr_oe), 32'd0);
        check("addr_out idle", 32'(addr_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
